config_bus_writer: RTL and testbench



---
 rtl/cfg_pkg.sv | 56 +++++
 rtl/cfg_read_pipe.sv | 30 +++
 rtl/config_bus_writer.sv | 244 ++++++++++++++++++++++++
 tb/tb_config_bus_writer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the config BRAM: address map, clock-init bit indices and
// the bus writer state type. Verify states exist only with CONFIG_WRITE_VERIFY_EN.
package cfg_pkg;

  localparam logic [5:0] ADDR_CTRL_FLAG        = 6'h00;
  localparam logic [5:0] ADDR_FPGA_INFO        = 6'h01;
  localparam logic [5:0] ADDR_SEQ_CYCLE        = 6'h02;
  localparam logic [5:0] ADDR_SEQ_DIV          = 6'h03;
  localparam logic [5:0] ADDR_WAVELENGTH       = 6'h08;
  localparam logic [5:0] ADDR_SEQ_SYNC_TIME_0  = 6'h09;
  localparam logic [5:0] ADDR_SEQ_SYNC_TIME_1  = 6'h0A;
  localparam logic [5:0] ADDR_SEQ_SYNC_TIME_2  = 6'h0B;
  localparam logic [5:0] ADDR_SEQ_SYNC_TIME_3  = 6'h0C;
  localparam logic [5:0] ADDR_MOD_CYCLE        = 6'h0D;
  localparam logic [5:0] ADDR_MOD_DIV          = 6'h0E;
  localparam logic [5:0] ADDR_MOD_SYNC_TIME_0  = 6'h0F;
  localparam logic [5:0] ADDR_MOD_SYNC_TIME_1  = 6'h10;
  localparam logic [5:0] ADDR_MOD_SYNC_TIME_2  = 6'h11;
  localparam logic [5:0] ADDR_MOD_SYNC_TIME_3  = 6'h12;
  localparam logic [5:0] ADDR_CLK_INIT_FLAG    = 6'h13;

  localparam int INIT_BIT_MOD = 0;
  localparam int INIT_BIT_SEQ = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WRITE,
`ifdef CONFIG_WRITE_VERIFY_EN
    ST_VERIFY_RD,
    ST_VERIFY_WAIT,
`endif
    ST_INIT_WR,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_INFO_RD,
    ST_INFO_WAIT,
    ST_FIN
  } state_t;

  // The FPGA side owns these two words; the host stream must never overwrite them.
  function automatic logic is_reserved(input logic [5:0] addr);
    return (addr == ADDR_FPGA_INFO) || (addr == ADDR_CLK_INIT_FLAG);
  endfunction

`ifdef CONFIG_WRITE_VERIFY_EN
  function automatic logic [5:0] lowest_set(input logic [63:0] mask);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (mask[i]) idx = 6'(i);
    end
    return idx;
  endfunction
`endif

endpackage

// File: rtl/cfg_read_pipe.sv
// Tracks one outstanding BRAM read and pulses o_valid on the cycle the read data
// is present on the bus, READ_LATENCY cycles after the enable cycle.
module cfg_read_pipe #(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_valid
);

  logic [READ_LATENCY-1:0] r_sr;

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sr <= '0;
      else        r_sr <= i_start;
    end
  end else begin : g_latn
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sr <= '0;
      else        r_sr <= {r_sr[READ_LATENCY-2:0], i_start};
    end
  end

  assign o_valid = r_sr[READ_LATENCY-1];

endmodule

// File: rtl/config_bus_writer.sv
// Host-side config writer: streams words into the config BRAM port, raises the
// clock-init flags, polls for their clearance and reads back the FPGA info word.
// Optional read-back verification of the burst: define CONFIG_WRITE_VERIFY_EN.
module config_bus_writer
  import cfg_pkg::*;
#(
  parameter int          POLL_TIMEOUT  = 4096,
  parameter int          READ_LATENCY  = 2,
  parameter logic [1:0]  CONFIG_SELECT = 2'h0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [5:0]  S_ADDR,
  input  logic [15:0] S_DATA,
  input  logic        S_LAST,
  input  logic [1:0]  INIT_REQ,
  output logic        BUS_EN,
  output logic        BUS_WE,
  output logic [1:0]  BUS_SELECT,
  output logic [5:0]  BUS_ADDR,
  output logic [15:0] BUS_WDATA,
  input  logic [15:0] BUS_RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  FPGA_INFO,
  output logic        TIMEOUT_ERR,
  output logic        ADDR_ERR,
  output logic        VERIFY_ERR
);

  localparam int              CNT_W   = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic             r_armed;
  logic [1:0]       r_init_req;
  logic [CNT_W-1:0] r_poll_cnt;
  logic [7:0]       r_fpga_info;
  logic             r_tmo_err;
  logic             r_addr_err;

  logic             w_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_reserved;
  logic             w_rd_start;
  logic             w_rd_valid;
  logic             w_set_tmo;
  logic             w_in_poll;
  state_t           w_after_burst;

`ifdef CONFIG_WRITE_VERIFY_EN
  logic [63:0]      r_written;
  logic             r_verify_err;
  logic [5:0]       r_vaddr;
  logic [15:0]      r_shadow [64];
  logic [5:0]       w_vaddr;
  logic             w_wr_beat;
`endif

  // r_armed holds S_READY low while reset is asserted, keeping every output at 0.
  assign w_ready    = r_armed && ((r_state == ST_IDLE) || (r_state == ST_WRITE));
  assign w_accept   = S_VALID && w_ready;
  assign w_first    = w_accept && (r_state == ST_IDLE);
  assign w_reserved = is_reserved(S_ADDR);
  assign w_in_poll  = (r_state == ST_POLL_RD) || (r_state == ST_POLL_WAIT);

`ifdef CONFIG_WRITE_VERIFY_EN
  assign w_after_burst = ST_VERIFY_RD;
  assign w_vaddr       = lowest_set(r_written);
  assign w_wr_beat     = w_accept && !w_reserved;
`else
  assign w_after_burst = (INIT_REQ != 2'b00) ? ST_INIT_WR : ST_INFO_RD;
`endif

  assign S_READY     = w_ready;
  assign BUS_SELECT  = CONFIG_SELECT;
  assign FPGA_INFO   = r_fpga_info;
  assign TIMEOUT_ERR = r_tmo_err;
  assign ADDR_ERR    = r_addr_err;

  cfg_read_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_start (w_rd_start),
    .o_valid (w_rd_valid)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_next     = r_state;
    BUS_EN     = 1'b0;
    BUS_WE     = 1'b0;
    BUS_ADDR   = '0;
    BUS_WDATA  = '0;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    w_rd_start = 1'b0;
    w_set_tmo  = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_WRITE: begin
        if (r_state == ST_IDLE) BUSY = w_accept;
        if (w_accept) begin
          BUS_EN    = 1'b1;
          BUS_WE    = !w_reserved;
          BUS_ADDR  = S_ADDR;
          BUS_WDATA = S_DATA;
          w_next    = S_LAST ? w_after_burst : ST_WRITE;
        end
      end
`ifdef CONFIG_WRITE_VERIFY_EN
      ST_VERIFY_RD: begin
        if (r_written == 64'd0) begin
          w_next = (!r_verify_err && (r_init_req != 2'b00)) ? ST_INIT_WR : ST_INFO_RD;
        end else begin
          BUS_EN     = 1'b1;
          BUS_ADDR   = w_vaddr;
          w_rd_start = 1'b1;
          w_next     = ST_VERIFY_WAIT;
        end
      end
      ST_VERIFY_WAIT: begin
        if (w_rd_valid) w_next = ST_VERIFY_RD;
      end
`endif
      ST_INIT_WR: begin
        BUS_EN    = 1'b1;
        BUS_WE    = 1'b1;
        BUS_ADDR  = ADDR_CLK_INIT_FLAG;
        BUS_WDATA = {14'd0, r_init_req};
        w_next    = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        BUS_EN     = 1'b1;
        BUS_ADDR   = ADDR_CLK_INIT_FLAG;
        w_rd_start = 1'b1;
        w_next     = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (w_rd_valid) begin
          if (BUS_RDATA == 16'd0) begin
            w_next = ST_INFO_RD;
          end else if (r_poll_cnt < CNT_MAX) begin
            w_next = ST_POLL_RD;
          end else begin
            w_set_tmo = 1'b1;
            w_next    = ST_INFO_RD;
          end
        end
      end
      ST_INFO_RD: begin
        BUS_EN     = 1'b1;
        BUS_ADDR   = ADDR_FPGA_INFO;
        w_rd_start = 1'b1;
        w_next     = ST_INFO_WAIT;
      end
      ST_INFO_WAIT: begin
        if (w_rd_valid) w_next = ST_FIN;
      end
      ST_FIN: begin
        BUSY   = 1'b0;
        DONE   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_armed     <= 1'b0;
      r_init_req  <= 2'b00;
      r_poll_cnt  <= '0;
      r_fpga_info <= '0;
      r_tmo_err   <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept && S_LAST) r_init_req <= INIT_REQ;

      // Sticky errors restart with each new burst.
      if (w_first) begin
        r_addr_err <= w_reserved;
        r_tmo_err  <= 1'b0;
      end else begin
        if (w_accept && w_reserved) r_addr_err <= 1'b1;
        if (w_set_tmo)              r_tmo_err  <= 1'b1;
      end

      if (r_state == ST_INIT_WR)                 r_poll_cnt <= '0;
      else if (w_in_poll && r_poll_cnt != CNT_MAX) r_poll_cnt <= r_poll_cnt + 1'b1;

      if ((r_state == ST_INFO_WAIT) && w_rd_valid) r_fpga_info <= BUS_RDATA[7:0];
    end
  end

`ifdef CONFIG_WRITE_VERIFY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_written    <= '0;
      r_verify_err <= 1'b0;
      r_vaddr      <= '0;
    end else begin
      if (w_first) begin
        r_written    <= w_wr_beat ? (64'd1 << S_ADDR) : 64'd0;
        r_verify_err <= 1'b0;
      end else if (w_wr_beat) begin
        r_written <= r_written | (64'd1 << S_ADDR);
      end else if ((r_state == ST_VERIFY_RD) && (r_written != 64'd0)) begin
        r_written <= r_written & ~(64'd1 << w_vaddr);
        r_vaddr   <= w_vaddr;
      end

      if ((r_state == ST_VERIFY_WAIT) && w_rd_valid && (BUS_RDATA != r_shadow[r_vaddr]))
        r_verify_err <= 1'b1;
    end
  end

  // NOTE: the shadow file has no reset; only entries marked in r_written are
  // ever compared, and dropping reset lets it map onto plain storage.
  always_ff @(posedge CLK) begin
    if (w_wr_beat) r_shadow[S_ADDR] <= S_DATA;
  end

  assign VERIFY_ERR = r_verify_err;
`else
  assign VERIFY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_config_bus_writer.sv
// Scoreboard bench for config_bus_writer: a BRAM model on the bus port, expected
// writes and end-of-sequence results queued by stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_config_bus_writer;

  localparam int RL = 2;
  localparam int PT = 64;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [5:0]  S_ADDR = '0;
  logic [15:0] S_DATA = '0;
  logic        S_LAST = 1'b0;
  logic [1:0]  INIT_REQ = '0;
  logic        BUS_EN, BUS_WE;
  logic [1:0]  BUS_SELECT;
  logic [5:0]  BUS_ADDR;
  logic [15:0] BUS_WDATA, BUS_RDATA;
  logic        BUSY, DONE;
  logic [7:0]  FPGA_INFO;
  logic        TIMEOUT_ERR, ADDR_ERR, VERIFY_ERR;

  always #5 CLK = ~CLK;

  config_bus_writer #(
    .POLL_TIMEOUT (PT),
    .READ_LATENCY (RL),
    .CONFIG_SELECT(2'h0)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_ADDR(S_ADDR), .S_DATA(S_DATA),
    .S_LAST(S_LAST), .INIT_REQ(INIT_REQ),
    .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_SELECT(BUS_SELECT), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA),
    .BUSY(BUSY), .DONE(DONE), .FPGA_INFO(FPGA_INFO),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ADDR_ERR(ADDR_ERR), .VERIFY_ERR(VERIFY_ERR)
  );

  typedef struct packed { logic [5:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic [7:0] info; logic tmo; logic aerr; logic verr; } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   mon_wr;
  done_t mon_done;

  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_poll = 0, n_info = 0, n_vrd = 0, acc_cyc = 0, done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- BRAM model (port A) ----------------
  logic [15:0] mem [64];
  logic [15:0] rd_pipe [RL];
  logic        clear_en = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [15:0] info_val = 16'hA5C3;
  int          clr_cnt = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (BUS_EN && BUS_WE) begin
      mem[BUS_ADDR] <= (corrupt_en && BUS_ADDR == 6'h02) ? (BUS_WDATA ^ 16'h0100) : BUS_WDATA;
      if (BUS_ADDR == 6'h13 && clear_en) clr_cnt <= 20;
    end else if (clr_cnt > 0) begin
      clr_cnt <= clr_cnt - 1;
      if (clr_cnt == 1) mem[6'h13] <= 16'h0000;
    end
    if (BUS_EN && !BUS_WE) rd_pipe[0] <= (BUS_ADDR == 6'h01) ? info_val : mem[BUS_ADDR];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign BUS_RDATA = rd_pipe[RL-1];

  // ---------------- Monitor ----------------
  always @(negedge CLK) begin
    if (RST_N) begin
      if (S_VALID && S_READY) acc_cyc = cyc;
      if (BUS_EN && BUS_WE) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_write: got addr %0h data %0h, expected no write", BUS_ADDR, BUS_WDATA);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("wr_addr", 32'(BUS_ADDR), 32'(mon_wr.addr));
          check("wr_data", 32'(BUS_WDATA), 32'(mon_wr.data));
        end
      end else if (BUS_EN && !(S_VALID && S_READY)) begin
        if (BUS_ADDR == 6'h13)      n_poll++;
        else if (BUS_ADDR == 6'h01) n_info++;
        else                        n_vrd++;
      end
      if (DONE) begin
        done_cyc = cyc;
        n_done++;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_pulse: got DONE, expected none");
        end else begin
          mon_done = exp_done.pop_front();
          check("fpga_info",   32'(FPGA_INFO),   32'(mon_done.info));
          check("timeout_err", 32'(TIMEOUT_ERR), 32'(mon_done.tmo));
          check("addr_err",    32'(ADDR_ERR),    32'(mon_done.aerr));
          check("verify_err",  32'(VERIFY_ERR),  32'(mon_done.verr));
          check("busy_at_done", 32'(BUSY), 32'd0);
        end
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic send_beat(input logic [5:0] a, input logic [15:0] d, input logic last,
                           input logic [1:0] init);
    int n;
    n = 0;
    S_VALID  = 1'b1;
    S_ADDR   = a;
    S_DATA   = d;
    S_LAST   = last;
    INIT_REQ = last ? init : 2'b00;
    if (!(a == 6'h01 || a == 6'h13)) exp_wr.push_back('{a, d});
    do begin
      @(negedge CLK);
      n++;
    end while (!S_READY && n < 200);
    if (!S_READY) fail_bound("beat_accept");
    @(posedge CLK);
    #2;
  endtask

  task automatic stop_stream();
    S_VALID  = 1'b0;
    S_LAST   = 1'b0;
    INIT_REQ = 2'b00;
  endtask

  task automatic wait_done(input int start_n);
    int n;
    n = 0;
    while (n_done == start_n && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (n_done == start_n) fail_bound("done_wait");
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},  32'(S_READY), 32'd0);
    check({tag, "_bus_en"},   32'(BUS_EN), 32'd0);
    check({tag, "_bus_we"},   32'(BUS_WE), 32'd0);
    check({tag, "_bus_sel"},  32'(BUS_SELECT), 32'd0);
    check({tag, "_bus_addr"}, 32'(BUS_ADDR), 32'd0);
    check({tag, "_bus_wd"},   32'(BUS_WDATA), 32'd0);
    check({tag, "_busy"},     32'(BUSY), 32'd0);
    check({tag, "_done"},     32'(DONE), 32'd0);
    check({tag, "_info"},     32'(FPGA_INFO), 32'd0);
    check({tag, "_tmo"},      32'(TIMEOUT_ERR), 32'd0);
    check({tag, "_aerr"},     32'(ADDR_ERR), 32'd0);
    check({tag, "_verr"},     32'(VERIFY_ERR), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed tests ----------------
  initial begin
    int sp, si, sd, sv;

    #1;
    check_reset_outputs("rst");
    #21;
    RST_N = 1'b1;
    @(posedge CLK);
    #2;

    // 1: two data writes, init flag write, polls until cleared, info read.
    clear_en = 1'b1;
    sp = n_poll; si = n_info; sd = n_done;
    exp_done.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
    send_beat(6'h0D, 16'h1000, 1'b0, 2'b00);
    stop_stream();
    @(negedge CLK);
    check("t1_gap_bus_idle", 32'(BUS_EN), 32'd0);
    check("t1_gap_busy", 32'(BUSY), 32'd1);
    @(posedge CLK);
    #2;
    send_beat(6'h0E, 16'h000A, 1'b1, 2'b01);
    exp_wr.push_back('{6'h13, 16'h0001});
    stop_stream();
    wait_done(sd);
    check("t1_polled_more_than_once", 32'(n_poll - sp > 1), 32'd1);
    check("t1_info_reads", 32'(n_info - si), 32'd1);
    check("t1_writes_drained", 32'(exp_wr.size()), 32'd0);

    // 2: flag never cleared -> 22 polls then timeout, info still read.
    clear_en = 1'b0;
    sp = n_poll; si = n_info; sd = n_done;
    exp_done.push_back('{8'hC3, 1'b1, 1'b0, 1'b0});
    send_beat(6'h0D, 16'h1000, 1'b0, 2'b00);
    send_beat(6'h0E, 16'h000A, 1'b1, 2'b01);
    exp_wr.push_back('{6'h13, 16'h0001});
    stop_stream();
    wait_done(sd);
    check("t2_poll_count", 32'(n_poll - sp), 32'd22);
    check("t2_info_reads", 32'(n_info - si), 32'd1);
    check("t2_tmo_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // 3: reserved-address beat is skipped and flagged; others written.
    clear_en = 1'b1;
    sd = n_done;
    exp_done.push_back('{8'hC3, 1'b0, 1'b1, 1'b0});
    send_beat(6'h13, 16'hFFFF, 1'b0, 2'b00);
    send_beat(6'h02, 16'h1234, 1'b0, 2'b00);
    send_beat(6'h03, 16'h0002, 1'b1, 2'b10);
    exp_wr.push_back('{6'h13, 16'h0002});
    stop_stream();
    wait_done(sd);
    repeat (3) @(posedge CLK);
    #2;
    check("t3_addr_err_sticky", 32'(ADDR_ERR), 32'd1);

    // 4: single LAST beat, no init -> no flag write, no poll, short latency.
    info_val = 16'h7F01;
    sp = n_poll; si = n_info; sd = n_done;
    exp_done.push_back('{8'h01, 1'b0, 1'b0, 1'b0});
    send_beat(6'h08, 16'h0640, 1'b1, 2'b00);
    stop_stream();
    wait_done(sd);
    check("t4_no_poll", 32'(n_poll - sp), 32'd0);
    check("t4_info_reads", 32'(n_info - si), 32'd1);
`ifndef CONFIG_WRITE_VERIFY_EN
    check("t4_latency_ok", 32'((done_cyc - acc_cyc + 1) <= (3 + RL)), 32'd1);
`endif

    // 5: reset while polling, then a clean burst.
    clear_en = 1'b0;
    sp = n_poll;
    send_beat(6'h01, 16'h0055, 1'b0, 2'b00);
    send_beat(6'h03, 16'h0007, 1'b1, 2'b01);
    exp_wr.push_back('{6'h13, 16'h0001});
    stop_stream();
    begin
      int n;
      n = 0;
      while (n_poll == sp && n < 500) begin
        @(negedge CLK);
        n++;
      end
      if (n_poll == sp) fail_bound("t5_poll_wait");
    end
    check("t5_addr_err_before_rst", 32'(ADDR_ERR), 32'd1);
    check("t5_flag_write_done", 32'(exp_wr.size()), 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
    clear_en = 1'b1;
    sp = n_poll; sd = n_done;
    exp_done.push_back('{8'h01, 1'b0, 1'b0, 1'b0});
    send_beat(6'h09, 16'h1111, 1'b0, 2'b00);
    send_beat(6'h0A, 16'h2222, 1'b1, 2'b00);
    stop_stream();
    wait_done(sd);
    check("t5_no_poll_after_rst", 32'(n_poll - sp), 32'd0);
    check("t5_writes_drained", 32'(exp_wr.size()), 32'd0);

`ifdef CONFIG_WRITE_VERIFY_EN
    // 6: corrupted read-back -> VERIFY_ERR, flag write skipped.
    corrupt_en = 1'b1;
    sp = n_poll; sv = n_vrd; sd = n_done;
    exp_done.push_back('{8'h01, 1'b0, 1'b0, 1'b1});
    send_beat(6'h02, 16'h00AA, 1'b0, 2'b00);
    send_beat(6'h0D, 16'h0003, 1'b1, 2'b01);
    stop_stream();
    wait_done(sd);
    check("t6_verify_reads", 32'(n_vrd - sv), 32'd2);
    check("t6_no_poll", 32'(n_poll - sp), 32'd0);
    corrupt_en = 1'b0;
`endif

    repeat (4) @(posedge CLK);
    #2;
    check("end_writes_drained", 32'(exp_wr.size()), 32'd0);
    check("end_done_drained", 32'(exp_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
